match_event_logger: RTL and testbench
=====================================

# match_event_logger

Downstream consumer of the serial 1010 sequence detector. It timestamps every qualified match pulse with the index of the input bit that completed it, keeps a saturating match count, and buffers the timestamps in a small FIFO. A host or debug bus drains the FIFO through a valid/ready interface. Lost events are flagged by a sticky overflow bit.

## Interface
Parameters:
- TS_W, 16: timestamp width in bits; the bit-index counter wraps modulo 2^TS_W.
- CNT_W, 16: width of the match counter; the counter saturates.
- DEPTH, 8: FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of all state.
- bit_valid  in  1  one detector input bit is consumed this cycle.
- match  in  1  detector `out`; sampled only when bit_valid=1.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head entry.
- ev_ts  out  TS_W  head timestamp; 0 when ev_valid=0.
- match_count  out  CNT_W  number of accepted matches, saturating.
- overflow  out  1  sticky; set when an event is dropped.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- ts counter:
  - Starts at 0.
  - Increments by 1 on every bit_valid cycle.
  - Wraps from 2^TS_W−1 to 0.
- Event: bit_valid && match.
  - The entry pushed is the ts value before the increment, i.e. the index of the bit that completed the match.
  - match asserted while bit_valid=0 is ignored entirely: no push, no count.
- match_count: +1 per event; holds at 2^CNT_W−1.
  - Counts every event, including dropped ones.
- Pop: ev_valid && ev_ready. FIFO is show-ahead; ev_ts is combinational from the head entry.
- Full FIFO:
  - Push without a same-cycle pop: the event is dropped, FIFO unchanged, overflow←1.
  - Push with a same-cycle pop: both occur, nothing is dropped, level unchanged.
- Empty FIFO: ev_ready is ignored and level stays 0.
- clear:
  - Zeroes ts, match_count, overflow, the FIFO pointers and level.
  - Takes priority over a same-cycle event or pop; that event is discarded and not counted.
- Reset: same effect as clear, asynchronous.
  - If reset is asserted mid-drain, all buffered entries are lost.
  - Reset values: ev_valid=0, ev_ts=0, match_count=0, overflow=0, fifo_level=0.

## Timing
- Event to ev_valid/ev_ts visible: 1 cycle (registered push).
- Event to match_count update: 1 cycle.
- Pop to next head on ev_ts: 1 cycle.
- fifo_level reflects the registered state; simultaneous push+pop leaves it unchanged.
- Sustained throughput: one event and one pop per cycle.
- ev_ts must be stable while ev_valid=1 && ev_ready=0.

## Configuration
- LOGGER_DROP_CNT_EN defined:
  - Adds output drop_count (8 bits, saturating at 255).
  - It increments on each dropped event and is cleared by clear and reset.
  - overflow behaviour is unchanged.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package match_logger_pkg holds:
  - default TS_W, CNT_W, DEPTH constants;
  - the drop-counter width constant (8);
  - a typedef for the timestamp word.
- One sub-module, event_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports: push, pop, din, dout, full, empty, level, plus synchronous clear;
  - show-ahead read.
- Top level holds the ts counter, match counter, overflow/drop logic and gating.

## Test plan
- Bits 1,0,1,0 with bit_valid every cycle from reset; match on bit index 3 → ev_valid=1 next cycle, ev_ts=3, match_count=1; ev_ready=1 → ev_valid=0 one cycle later.
- match pulses with bit_valid=0 → no push, match_count stays 0, ts unchanged.
- DEPTH=8, ev_ready=0, 9 events at ts 3,7,…,35 → level=8, overflow=1, ninth dropped, match_count=9, drop_count=1 (macro on). Drain returns 3…31 in order.
- FIFO full, event coincides with pop → no drop, level stays 8, overflow stays 0, new timestamp appears last.
- TS_W=4: event at bit index 15, then event at bit index 17 → entries 15 and 1 (wrap).
- clear in the same cycle as an event with 3 entries buffered → next cycle level=0, ev_valid=0, match_count=0, overflow=0; reset asserted mid-drain → same result asynchronously.

Source files
------------

// File: rtl/match_logger_pkg.sv
// Shared constants and types for the match event logger.
// Optional drop counter: LOGGER_DROP_CNT_EN.
package match_logger_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int DROP_W    = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/match_event_logger_event_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear.
// A push into a full FIFO only succeeds alongside a pop.
module event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q];
    assign level   = level_q;

    // Pointer and occupancy bookkeeping; clear wins over any traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps qualified 1010 matches and buffers them for a host.
// Optional drop counter: LOGGER_DROP_CNT_EN.
module match_event_logger
    import match_logger_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   bit_valid,
    input  logic                   match,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [CNT_W-1:0]       match_count,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef LOGGER_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]      drop_count
`endif
);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ev, drop, full, empty;
    logic [TS_W-1:0]  head;

    assign ev   = bit_valid && match;
    assign drop = ev && full && !ev_ready;

    event_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (ev),
        .pop   (ev_ready),
        .din   (ts_q),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign ev_valid    = !empty;
    assign ev_ts       = empty ? '0 : head;
    assign match_count = cnt_q;
    assign overflow    = ovf_q;

    // Next-state for bit index, saturating match count and sticky overflow.
    always_comb begin
        ts_d  = ts_q + TS_W'(bit_valid);
        cnt_d = cnt_q;
        if (ev && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | drop;
    end

    // Counter state registers; clear has priority over events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            ts_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef LOGGER_DROP_CNT_EN
    logic [DROP_W-1:0] drop_q;

    assign drop_count = drop_q;

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (clear) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Scoreboard bench for match_event_logger.
// Exercises LOGGER_DROP_CNT_EN checks when that macro is defined.
module tb_match_event_logger;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear, bit_valid, match, ev_ready;
    logic        ev_valid, overflow;
    logic [15:0] ev_ts, match_count;
    logic [3:0]  fifo_level;
`ifdef LOGGER_DROP_CNT_EN
    logic [7:0]  drop_count;
    logic [7:0]  drop_count4;
`endif

    logic        clear4, bit_valid4, match4, ev_ready4;
    logic        ev_valid4, overflow4;
    logic [3:0]  ev_ts4;
    logic [15:0] match_count4;
    logic [2:0]  fifo_level4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sb_q[$];
    int unsigned mts;
    int unsigned mcnt;
    int unsigned mdrop;
    bit          movf;

    always #5 clk = ~clk;

    match_event_logger dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .bit_valid   (bit_valid),
        .match       (match),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ts       (ev_ts),
        .match_count (match_count),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
`ifdef LOGGER_DROP_CNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

    match_event_logger #(
        .TS_W  (4),
        .CNT_W (16),
        .DEPTH (4)
    ) dut4 (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear4),
        .bit_valid   (bit_valid4),
        .match       (match4),
        .ev_valid    (ev_valid4),
        .ev_ready    (ev_ready4),
        .ev_ts       (ev_ts4),
        .match_count (match_count4),
        .overflow    (overflow4),
        .fifo_level  (fifo_level4)
`ifdef LOGGER_DROP_CNT_EN
        ,
        .drop_count  (drop_count4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        mts   = 0;
        mcnt  = 0;
        mdrop = 0;
        movf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(ev_valid), 32'(sb_q.size() != 0));
        chk({tag, ".ts"}, 32'(ev_ts),
            (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
        chk({tag, ".lvl"}, 32'(fifo_level), 32'(sb_q.size()));
        chk({tag, ".cnt"}, 32'(match_count), mcnt);
        chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
`ifdef LOGGER_DROP_CNT_EN
        chk({tag, ".drop"}, 32'(drop_count), mdrop);
`endif
    endtask

    // Drive one cycle, advance the model at the edge, compare after it.
    task automatic step(input string tag, input logic bv, input logic m,
                        input logic rdy, input logic clr);
        bit pop;
        bit ev;
        bit dropped;
        bit_valid = bv;
        match     = m;
        ev_ready  = rdy;
        clear     = clr;
        @(posedge clk);
        pop     = rdy && (sb_q.size() != 0);
        ev      = bv && m;
        dropped = 1'b0;
        if (clr) begin
            model_clear();
        end else begin
            if (ev) begin
                if (mcnt != 32'hFFFF) mcnt++;
                if (sb_q.size() == 8 && !pop) begin
                    dropped = 1'b1;
                    movf    = 1'b1;
                    if (mdrop != 255) mdrop++;
                end
            end
            if (pop) void'(sb_q.pop_front());
            if (ev && !dropped) sb_q.push_back(16'(mts));
            mts = (mts + 32'(bv)) & 32'hFFFF;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        {clear, bit_valid, match, ev_ready} = '0;
        {clear4, bit_valid4, match4, ev_ready4} = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        reset = 1'b0;

        // match without bit_valid is ignored
        repeat (3) step("nobv", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("nobv.cnt0", 32'(match_count), 32'd0);

        // 1,0,1,0 with match on bit 3
        for (int i = 0; i < 3; i++) step("seq", 1'b1, 1'b0, 1'b0, 1'b0);
        step("seq3", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq3.ts", 32'(ev_ts), 32'd3);
        chk("seq3.cnt", 32'(match_count), 32'd1);
        step("seqpop", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("seqpop.valid", 32'(ev_valid), 32'd0);

        // overflow: nine events into an eight-deep FIFO
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 36; i++)
            step("ovf", 1'b1, 1'(i % 4 == 3), 1'b0, 1'b0);
        chk("ovf.lvl8", 32'(fifo_level), 32'd8);
        chk("ovf.sticky", 32'(overflow), 32'd1);
        chk("ovf.cnt9", 32'(match_count), 32'd9);
`ifdef LOGGER_DROP_CNT_EN
        chk("ovf.drop1", 32'(drop_count), 32'd1);
`endif
        repeat (3) step("hold", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("drain.ts", 32'(ev_ts), 32'(3 + 4 * i));
            step("drain", 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // full FIFO with coincident push and pop
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++)
            step("fill", 1'b1, 1'(i % 4 == 3), 1'b0, 1'b0);
        step("both", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("both.lvl8", 32'(fifo_level), 32'd8);
        chk("both.ovf0", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) step("bdrain", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("both.last", 32'(ev_ts), 32'd32);
        step("bdrain", 1'b0, 1'b0, 1'b1, 1'b0);
        step("empty", 1'b0, 1'b0, 1'b1, 1'b0);

        // clear coinciding with an event
        step("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            step("three", 1'b1, 1'(i % 4 == 3), 1'b0, 1'b0);
        chk("three.lvl", 32'(fifo_level), 32'd3);
        step("clrev", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clrev.lvl", 32'(fifo_level), 32'd0);
        chk("clrev.cnt", 32'(match_count), 32'd0);

        // asynchronous reset mid-drain
        for (int i = 0; i < 12; i++)
            step("refill", 1'b1, 1'(i % 4 == 3), 1'b0, 1'b0);
        step("mid", 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        model_clear();
        check_all("arst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("post", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4-bit timestamp wrap on the second instance
        for (int i = 0; i < 18; i++) begin
            bit_valid4 = 1'b1;
            match4     = (i == 15) || (i == 17);
            ev_ready4  = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_valid4 = 1'b0;
        match4     = 1'b0;
        chk("wrap.lvl", 32'(fifo_level4), 32'd2);
        chk("wrap.ts0", 32'(ev_ts4), 32'd15);
        ev_ready4 = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap.ts1", 32'(ev_ts4), 32'd1);
        chk("wrap.valid", 32'(ev_valid4), 32'd1);
        @(posedge clk);
        #1;
        chk("wrap.empty", 32'(ev_valid4), 32'd0);
        chk("wrap.cnt", 32'(match_count4), 32'd2);
        ev_ready4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
